// File: rtl/prbs_checker.sv
// Self-synchronizing PRBS receive checker: fills a local LFSR from the line,
// verifies predictions until lock, then free-runs and counts bit errors.
module prbs_checker #(
   parameter int               NBITS    = 8,
   parameter logic [NBITS-1:0] TAPS     = 8'hB8,
   parameter int               LOCK_CNT = 16,
   parameter int               LOSS_CNT = 4,
   parameter int               ERR_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             din,
   input  logic             clr,
   output logic             locked,
   output logic             err,
   output logic [ERR_W-1:0] err_count
);

   localparam int FW = $clog2(NBITS + 1);

   typedef enum logic [1:0] {
      FILL,
      VERIFY,
      LOCKED
   } state_t;

   state_t           state, state_nx;
   logic [NBITS-1:0] s, s_nx;
   logic [FW-1:0]    fcnt, fcnt_nx;
   logic [7:0]       mcnt, mcnt_nx;
   logic [7:0]       lcnt, lcnt_nx;
   logic             p;
   logic             miss;
   logic             inc;

   assign p    = ^(s & TAPS);
   assign miss = din ^ p;

   always_comb begin
      state_nx = state;
      s_nx     = s;
      fcnt_nx  = fcnt;
      mcnt_nx  = mcnt;
      lcnt_nx  = lcnt;
      inc      = 1'b0;
      if (en) begin
         unique case (state)
            FILL: begin
               s_nx    = {s[NBITS-2:0], din};
               fcnt_nx = fcnt + FW'(1);
               if (fcnt == FW'(NBITS - 1)) begin
                  fcnt_nx = '0;
                  // an all-zero register would lock onto a dead stream
                  if (s_nx != '0) begin
                     state_nx = VERIFY;
                     mcnt_nx  = '0;
                  end
               end
            end
            VERIFY: begin
               s_nx = {s[NBITS-2:0], din};
               if (!miss) begin
                  mcnt_nx = mcnt + 8'd1;
                  if (mcnt_nx == 8'(LOCK_CNT)) begin
                     state_nx = LOCKED;
                     lcnt_nx  = '0;
                  end
               end else begin
                  state_nx = FILL;
                  fcnt_nx  = '0;
               end
            end
            LOCKED: begin
               // free-run on our own prediction so a line error counts once
               s_nx = {s[NBITS-2:0], p};
               if (miss) begin
                  inc     = 1'b1;
                  lcnt_nx = lcnt + 8'd1;
                  if (lcnt_nx == 8'(LOSS_CNT)) begin
                     state_nx = FILL;
                     fcnt_nx  = '0;
                  end
               end else begin
                  lcnt_nx = '0;
               end
            end
            default: state_nx = FILL;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FILL;
         s     <= '0;
         fcnt  <= '0;
         mcnt  <= '0;
         lcnt  <= '0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         s     <= s_nx;
         fcnt  <= fcnt_nx;
         mcnt  <= mcnt_nx;
         lcnt  <= lcnt_nx;
         err   <= inc;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count <= '0;
      end else if (clr) begin
         err_count <= '0;
      end else if (inc && (err_count != '1)) begin
         err_count <= err_count + ERR_W'(1);
      end
   end

   assign locked = (state == LOCKED);

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: phase table with hand-derived end results,
// corner sequences, and randomized traffic against a queue-based model.
module tb_prbs_checker;

   localparam int NB = 8;
   localparam logic [7:0] TP = 8'hB8;
   localparam int LOCKN = 16;
   localparam int LOSSN = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic        din = 1'b0;
   logic        clr = 1'b0;
   logic        locked, err, locked4, err4;
   logic [15:0] err_count;
   logic [3:0]  err_count4;

   prbs_checker dut (
      .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
      .locked(locked), .err(err), .err_count(err_count)
   );

   prbs_checker #(.ERR_W(4)) dut4 (
      .clk(clk), .rst(rst), .en(en), .din(din), .clr(clr),
      .locked(locked4), .err(err4), .err_count(err_count4)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int fails = 0;
   int pulses = 0;
   int vcount = 0;
   int rise_at = 0;
   int cyc_no = 0;

   // reference model: history of the local sequence, newest at the back
   bit hist[$];
   int m_mode, m_fill, m_match, m_miss;
   int m_err, m_cnt, m_cnt4;

   // stream generator: seed bits then the tap recurrence
   bit gq[$];
   logic [7:0] seed = 8'h01;

   function automatic bit taps_xor(input bit q[$]);
      bit r = 1'b0;
      for (int i = 0; i < NB; i++)
         if (TP[i]) r ^= q[q.size() - 1 - i];
      return r;
   endfunction

   function automatic bit gen_next();
      bit b;
      if (gq.size() < NB) b = seed[7 - gq.size()];
      else b = taps_xor(gq);
      gq.push_back(b);
      if (gq.size() > NB) void'(gq.pop_front());
      return b;
   endfunction

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < NB; i++) hist.push_back(1'b0);
      m_mode = 0; m_fill = 0; m_match = 0; m_miss = 0;
      m_err = 0; m_cnt = 0; m_cnt4 = 0;
   endtask

   task automatic push_hist(input bit b);
      hist.push_back(b);
      void'(hist.pop_front());
   endtask

   task automatic model_step(input bit e, input bit d, input bit c);
      bit p;
      bit nz;
      m_err = 0;
      if (e) begin
         p = taps_xor(hist);
         if (m_mode == 0) begin
            push_hist(d);
            m_fill++;
            if (m_fill == NB) begin
               m_fill = 0;
               nz = 1'b0;
               foreach (hist[i]) nz |= hist[i];
               if (nz) begin m_mode = 1; m_match = 0; end
            end
         end else if (m_mode == 1) begin
            push_hist(d);
            if (d == p) begin
               m_match++;
               if (m_match == LOCKN) begin m_mode = 2; m_miss = 0; end
            end else begin
               m_mode = 0; m_fill = 0;
            end
         end else begin
            push_hist(p);
            if (d != p) begin
               m_err = 1;
               m_miss++;
               if (m_miss == LOSSN) begin m_mode = 0; m_fill = 0; end
            end else begin
               m_miss = 0;
            end
         end
      end
      if (c) begin
         m_cnt = 0; m_cnt4 = 0;
      end else if (m_err != 0) begin
         if (m_cnt < 65535) m_cnt++;
         if (m_cnt4 < 15) m_cnt4++;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cmp_model();
      int ml;
      ml = (m_mode == 2) ? 1 : 0;
      checks++;
      if (locked !== ml[0] || err !== m_err[0] || err_count !== m_cnt[15:0] ||
          locked4 !== ml[0] || err4 !== m_err[0] || err_count4 !== m_cnt4[3:0]) begin
         fails++;
         $display("FAIL cycle %0d: got L%b E%b C%0d / L%b E%b C%0d expected L%0d E%0d C%0d / C%0d",
                  cyc_no, locked, err, err_count, locked4, err4, err_count4,
                  ml, m_err, m_cnt, m_cnt4);
      end
   endtask

   task automatic cyc(input bit e, input bit d, input bit c);
      @(negedge clk);
      en = e; din = d; clr = c;
      @(posedge clk);
      model_step(e, d, c);
      cyc_no++;
      if (e) vcount++;
      #1;
      cmp_model();
      if (err) pulses++;
      if (locked && rise_at == 0) rise_at = vcount;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; en = 1'b0; clr = 1'b0;
      #1;
      model_reset();
      gq.delete();
      vcount = 0; rise_at = 0;
      cmp_model();
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef enum int {CLEAN, FLIP, ZERO, GAP, SPARSE} pmode_t;
   typedef struct {
      int     rst_first;
      pmode_t mode;
      int     n;
      int     exp_locked;
      int     exp_cnt;
      int     exp_cnt4;
      int     exp_pulses;
   } phase_t;

   phase_t tbl[10];

   initial begin
      bit hi_rate;
      bit b;
      tbl[0] = '{1, CLEAN, 300, 1, 0, 0, 0};
      tbl[1] = '{0, FLIP, 1, 1, 1, 1, 1};
      tbl[2] = '{0, CLEAN, 50, 1, 1, 1, 0};
      tbl[3] = '{0, FLIP, 4, 0, 5, 5, 4};
      tbl[4] = '{0, CLEAN, 23, 0, 5, 5, 0};
      tbl[5] = '{0, CLEAN, 1, 1, 5, 5, 0};
      tbl[6] = '{1, ZERO, 100, 0, 0, 0, 0};
      tbl[7] = '{1, GAP, 23, 0, 0, 0, 0};
      tbl[8] = '{0, GAP, 1, 1, 0, 0, 0};
      tbl[9] = '{0, SPARSE, 20, 1, 20, 15, 20};

      model_reset();
      rst = 1'b1;
      #2;
      chk("reset_locked", int'(locked), 0);
      chk("reset_err", int'(err), 0);
      chk("reset_count", int'(err_count), 0);
      rst = 1'b0;

      for (int k = 0; k < 10; k++) begin
         if (tbl[k].rst_first != 0) do_reset();
         pulses = 0;
         for (int j = 0; j < tbl[k].n; j++) begin
            case (tbl[k].mode)
               CLEAN:  cyc(1'b1, gen_next(), 1'b0);
               FLIP:   cyc(1'b1, ~gen_next(), 1'b0);
               ZERO:   cyc(1'b1, 1'b0, 1'b0);
               GAP: begin
                  cyc(1'b1, gen_next(), 1'b0);
                  cyc(1'b0, 1'($urandom), 1'b0);
               end
               default: begin
                  cyc(1'b1, ~gen_next(), 1'b0);
                  cyc(1'b1, gen_next(), 1'b0);
                  cyc(1'b1, gen_next(), 1'b0);
               end
            endcase
         end
         chk($sformatf("phase%0d_locked", k), int'(locked), tbl[k].exp_locked);
         chk($sformatf("phase%0d_count", k), int'(err_count), tbl[k].exp_cnt);
         chk($sformatf("phase%0d_count4", k), int'(err_count4), tbl[k].exp_cnt4);
         chk($sformatf("phase%0d_pulses", k), pulses, tbl[k].exp_pulses);
         if (k == 0) chk("clean_lock_point", rise_at, 24);
         if (k == 8) chk("gapped_lock_point", rise_at, 24);
      end

      // clear wins over a same-cycle error, pulse still produced
      cyc(1'b1, ~gen_next(), 1'b1);
      chk("clr_err_pulse", int'(err), 1);
      chk("clr_count", int'(err_count), 0);
      chk("clr_count4", int'(err_count4), 0);
      cyc(1'b1, gen_next(), 1'b0);
      chk("clr_err_drop", int'(err), 0);

      // async reset while locked, away from any clock edge
      cyc(1'b1, ~gen_next(), 1'b0);
      chk("pre_rst_locked", int'(locked), 1);
      chk("pre_rst_count", int'(err_count), 1);
      @(negedge clk);
      en = 1'b1; din = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("async_locked", int'(locked), 0);
      chk("async_count", int'(err_count), 0);
      chk("async_err", int'(err), 0);
      model_reset();
      gq.delete();
      @(negedge clk);
      rst = 1'b0;
      en = 1'b0;

      // randomized traffic with alternating low and high error rates
      for (int i = 0; i < 4000; i++) begin
         hi_rate = ((i / 500) % 4) == 3;
         if (($urandom % 4) == 0) begin
            cyc(1'b0, 1'($urandom), (($urandom % 97) == 0));
         end else begin
            b = gen_next();
            if (hi_rate ? (($urandom % 2) == 0) : (($urandom % 40) == 0)) b = ~b;
            cyc(1'b1, b, (($urandom % 200) == 0));
         end
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
